// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and defaults for the fetch program counter
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    PEND_BR = 2'd2
  } pc_state_t;

  localparam int          DEF_XLEN         = 32;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'hbfc00000;
  localparam int          DEF_STEP         = 4;

endpackage

// File: rtl/pc_redirect_arb.sv
// rtl/pc_redirect_arb.sv - fixed-priority redirect encoder for the fetch PC
module pc_redirect_arb
  import pc_pkg::*;
#(
  parameter int              XLEN         = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter int              STEP         = DEF_STEP,
  parameter bit              DELAY_SLOT   = 1'b1
) (
  input  pc_state_t        state,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  pending,
  input  logic             fire,
  input  logic             dbg_reset,
  input  logic             dbg_valid,
  input  logic [XLEN-1:0]  dbg_target,
  input  logic             exc_valid,
  input  logic [XLEN-1:0]  exc_target,
  input  logic             br_valid,
  input  logic [XLEN-1:0]  br_target,
  output logic [XLEN-1:0]  next_pc,
  output pc_state_t        next_state,
  output logic             load_pending,
  output logic             clear_pending,
  output logic             set_overrun,
  output logic             clear_overrun
);

  // One action per cycle, highest-priority event first.
  always_comb begin
    next_pc       = pc;
    next_state    = state;
    load_pending  = 1'b0;
    clear_pending = 1'b0;
    set_overrun   = 1'b0;
    clear_overrun = 1'b0;
    if (dbg_reset) begin
      next_pc       = RESET_VECTOR;
      next_state    = BOOT;
      clear_pending = 1'b1;
      clear_overrun = 1'b1;
    end else if (dbg_valid) begin
      next_pc       = dbg_target;
      next_state    = RUN;
      clear_pending = 1'b1;
    end else if (exc_valid) begin
      next_pc       = exc_target;
      next_state    = RUN;
      clear_pending = 1'b1;
    end else if (br_valid && !DELAY_SLOT) begin
      next_pc    = br_target;
      next_state = RUN;
    end else if (br_valid && state == PEND_BR) begin
      // A second branch cannot be queued; flag it and keep draining the first.
      set_overrun = 1'b1;
      if (fire) begin
        next_pc    = pending;
        next_state = RUN;
      end
    end else if (br_valid) begin
      // The accepted fetch is the delay slot, so the target follows it directly.
      if (fire) begin
        next_pc    = br_target;
        next_state = RUN;
      end else begin
        load_pending = 1'b1;
        next_state   = PEND_BR;
      end
    end else if (fire) begin
      if (state == PEND_BR) begin
        next_pc    = pending;
        next_state = RUN;
      end else begin
        next_pc = pc + XLEN'(STEP);
      end
    end else if (state == BOOT) begin
      next_state = RUN;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch program counter with valid/ready request and redirects
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN         = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter int              STEP         = DEF_STEP,
  parameter int              ALIGN_BITS   = 2,
  parameter bit              DELAY_SLOT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [XLEN-1:0]  pc_out,
  output logic [XLEN-1:0]  pc_plus_step,
  output logic             pc_valid,
  input  logic             pc_ready,
  output logic             pc_misalign,
  input  logic             br_valid,
  input  logic [XLEN-1:0]  br_target,
  input  logic             exc_valid,
  input  logic [XLEN-1:0]  exc_target,
  input  logic             dbg_valid,
  input  logic [XLEN-1:0]  dbg_target,
  input  logic             dbg_reset,
  output logic             br_overrun
);

  pc_state_t       state;
  pc_state_t       next_state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] pending;
  logic            fire;
  logic            load_pending;
  logic            clear_pending;
  logic            set_overrun;
  logic            clear_overrun;

  // Valid depends only on registered state, never on pc_ready.
  assign pc_valid     = (state != BOOT);
  assign fire         = pc_valid & pc_ready;
  assign pc_out       = pc;
  assign pc_plus_step = pc + XLEN'(STEP);

  generate
    if (ALIGN_BITS > 0) begin : g_align
      assign pc_misalign = (pc[ALIGN_BITS-1:0] != '0);
    end else begin : g_no_align
      assign pc_misalign = 1'b0;
    end
  endgenerate

  pc_redirect_arb #(
    .XLEN         (XLEN),
    .RESET_VECTOR (RESET_VECTOR),
    .STEP         (STEP),
    .DELAY_SLOT   (DELAY_SLOT)
  ) u_arb (
    .state         (state),
    .pc            (pc),
    .pending       (pending),
    .fire          (fire),
    .dbg_reset     (dbg_reset),
    .dbg_valid     (dbg_valid),
    .dbg_target    (dbg_target),
    .exc_valid     (exc_valid),
    .exc_target    (exc_target),
    .br_valid      (br_valid),
    .br_target     (br_target),
    .next_pc       (next_pc),
    .next_state    (next_state),
    .load_pending  (load_pending),
    .clear_pending (clear_pending),
    .set_overrun   (set_overrun),
    .clear_overrun (clear_overrun)
  );

  // PC and state register; reset drops any outstanding request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_VECTOR;
      state <= BOOT;
    end else begin
      pc    <= next_pc;
      state <= next_state;
    end
  end

  // Latched branch target and the sticky overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      br_overrun <= 1'b0;
    end else begin
      if (clear_pending) begin
        pending <= '0;
      end else if (load_pending) begin
        pending <= br_target;
      end
      if (clear_overrun) begin
        br_overrun <= 1'b0;
      end else if (set_overrun) begin
        br_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised successor to the fetch-stage program counter.
- Generates the instruction-fetch address stream and presents it to instruction memory over a valid/ready handshake.
- Arbitrates redirects by fixed priority: debug reset, debug entry, exception, branch.
- Optionally implements a MIPS-style branch delay slot by holding a branch target until the delay-slot fetch is accepted.

Parameters:
- XLEN, 32, address width in bits.
- RESET_VECTOR, 32'hbfc00000, PC loaded on reset and on dbg_reset; XLEN bits wide.
- STEP, 4, sequential increment in bytes.
- ALIGN_BITS, 2, low PC bits that must be zero; anything else raises pc_misalign.
- DELAY_SLOT, 1, 1 = branch takes effect after the next accepted fetch; 0 = branch redirects immediately.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- pc_out  out  XLEN  current fetch address.
- pc_plus_step  out  XLEN  pc_out + STEP, modulo 2^XLEN.
- pc_valid  out  1  pc_out is a live fetch request.
- pc_ready  in  1  instruction memory accepts pc_out this cycle.
- pc_misalign  out  1  combinational: pc_out[ALIGN_BITS-1:0] != 0.
- br_valid  in  1  branch resolved taken; single-cycle pulse.
- br_target  in  XLEN  branch target address.
- exc_valid  in  1  exception redirect pulse.
- exc_target  in  XLEN  exception handler address.
- dbg_valid  in  1  debug-entry redirect pulse.
- dbg_target  in  XLEN  debug handler address.
- dbg_reset  in  1  synchronous soft reset to RESET_VECTOR.
- br_overrun  out  1  sticky flag: a branch arrived while a branch was pending; cleared only by reset or dbg_reset.

Behaviour:
- Reset (rst_n=0, asynchronous): pc_out=RESET_VECTOR, pc_valid=0, br_overrun=0, pending target cleared, state=BOOT.
- States:
  - BOOT: pc_valid=0. Goes to RUN on the next clk unless a higher-priority event applies.
  - RUN: pc_valid=1, no branch pending.
  - PEND_BR: pc_valid=1, a branch target is latched.
- fire = pc_valid & pc_ready.
- Per-cycle priority, highest first (exactly one action per cycle):
  1. dbg_reset: pc<=RESET_VECTOR, state<=BOOT, pending cleared, br_overrun<=0.
  2. dbg_valid: pc<=dbg_target, state<=RUN, pending discarded.
  3. exc_valid: pc<=exc_target, state<=RUN, pending discarded.
  4. br_valid:
     - DELAY_SLOT=0: pc<=br_target, state<=RUN.
     - DELAY_SLOT=1, RUN, fire: the accepted pc is the delay slot; pc<=br_target, state stays RUN.
     - DELAY_SLOT=1, RUN, no fire: pending<=br_target, state<=PEND_BR, pc unchanged.
     - DELAY_SLOT=1, PEND_BR: br_overrun<=1. The new branch is ignored, and the fire rule below still applies.
  5. fire:
     - In RUN: pc<=pc+STEP.
     - In PEND_BR: pc<=pending, state<=RUN.
  6. Otherwise: hold pc and state.
- Handshake:
  - While pc_valid=1 and pc_ready=0, pc_out stays stable, except for a redirect from priority 1-3, or a priority-4 branch with DELAY_SLOT=0.
  - Such a redirect withdraws the unaccepted request. Instruction memory must tolerate a changed address under valid.
- Redirects take effect on the next clk edge, so the first redirected address appears one cycle after the pulse.
- pc_valid is never a combinational function of pc_ready.
- Arithmetic: all additions wrap modulo 2^XLEN, so pc=2^XLEN-STEP advances to 0.
- Redirect targets are loaded unmodified. Misalignment is only flagged (pc_misalign), never corrected.
- Reset mid-handshake: the outstanding request is dropped. The first post-reset request is RESET_VECTOR, with pc_valid rising one cycle after rst_n deasserts.

Decomposition:
- pc_pkg holds:
  - the state enum (BOOT, RUN, PEND_BR);
  - the default XLEN and RESET_VECTOR constants;
  - the STEP default.
- One sub-module, pc_redirect_arb: combinational priority encoder producing next_pc, next_state and a load_pending strobe from the event inputs.
- pc_gen keeps the registers, the pending-target register and the br_overrun flag.

Test Plan:
- Reset release with pc_ready=1 held high -> cycle 1 after release: pc_valid=1, pc_out=bfc00000; next cycles bfc00004, then bfc00008.
- pc_ready=0 for 3 cycles at pc=bfc00010 -> pc_out stays bfc00010; after ready rises, bfc00014.
- DELAY_SLOT=1, br_valid with br_target=80000100 at pc=bfc00020, pc_ready=0, then ready next cycle -> bfc00020 accepted, then pc_out=80000100. Same stimulus with ready=1 in the br_valid cycle -> 80000100 on the next cycle.
- exc_valid (target bfc00380) and br_valid in the same cycle, and exc_valid while in PEND_BR -> pc_out=bfc00380, pending branch never taken.
- Second br_valid while in PEND_BR -> br_overrun=1, first target still taken; dbg_reset -> br_overrun=0, pc_out=bfc00000, pc_valid=0 for one cycle.
- XLEN=16, pc=FFFC, fire -> pc_out=0000. dbg_target=80000102 -> pc_misalign=1.
